uart_rx: RTL

Serial-to-parallel UART receiver, 8N1, LSB first, idle-high line. It is the receive-side counterpart of `uart_tx`. It accepts the host serial line (or `uart_tx.axiod` in loopback) and delivers each received byte as a one-cycle valid pulse into the nonogram command/clue loader. Start bits are validated at mid-bit, data and stop bits are sampled at bit centre, and a bad stop bit raises a framing-error pulse.

---
 rtl/uart_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line. Start validated at mid-bit,
// data/stop sampled at bit centre; a bad stop bit pulses ferr and re-hunts for idle.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       axiid,
   output logic       axiov,
   output logic [7:0] axiod,
   output logic       ferr,
   output logic       busy
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   // Counters compare against N-1 so CW bits suffice even for power-of-two rates.
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q, sync_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic [7:0]      axiod_q, axiod_d;
   logic            axiov_q, axiov_d;
   logic            ferr_q, ferr_d;
   logic            busy_q, busy_d;
   logic            rx_s;

   assign rx_s = sync_q[1];

   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[0], axiid};
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      axiod_d = axiod_q;
      axiov_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (!rx_s) begin
               cnt_d = '0;
            end else if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  axiod_d = sh_q;
                  axiov_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = HUNT;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = HUNT;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         axiod_q <= '0;
         axiov_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         axiod_q <= axiod_d;
         axiov_q <= axiov_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign axiov = axiov_q;
   assign axiod = axiod_q;
   assign ferr  = ferr_q;
   assign busy  = busy_q;
endmodule
